audio_sample_fifo: RTL and testbench



---
 rtl/nextasic_audio_pkg.sv | 17 +
 rtl/sample_ram.sv | 23 ++
 rtl/audio_sample_fifo.sv | 139 +++++++++++++
 tb/tb_audio_sample_fifo.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/nextasic_audio_pkg.sv
// Shared constants and state encoding for the audio sample path.
package nextasic_audio_pkg;

  localparam int SAMPLE_W  = 32;
  localparam int DEF_DEPTH = 16;
  localparam int DEF_AW    = 4;
  localparam int DEF_BURST = 4;
  localparam int DEF_PRIME = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_PLAY  = 2'd2,
    ST_DRAIN = 2'd3
  } audio_fifo_state_t;

endpackage

// File: rtl/sample_ram.sv
// DEPTH x W register array: one synchronous write port, one asynchronous read port.
module sample_ram #(
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int W     = 32
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [W-1:0]  i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [W-1:0]  o_rdata
);

  logic [W-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/audio_sample_fifo.sv
// Elastic sample buffer between packet decode and the I2S serializer, with
// prime/play/drain sequencing and burst request flow control toward the host.
module audio_sample_fifo
  import nextasic_audio_pkg::*;
#(
  parameter int DEPTH       = DEF_DEPTH,
  parameter int AW          = DEF_AW,
  parameter int BURST       = DEF_BURST,
  parameter int PRIME_LEVEL = DEF_PRIME
) (
  input  logic                mon_clk,
  input  logic                reset_n,
  input  logic                in_valid,
  input  logic [SAMPLE_W-1:0] in_data,
  input  logic                audio_starts,
  input  logic                audio_stop,
  input  logic                out_ready,
  output logic [SAMPLE_W-1:0] out_data,
  output logic                out_valid,
  output logic                audio_req,
  output logic [AW:0]         level,
  output logic                overflow,
  output logic                underrun
);

  localparam logic [AW:0] LP_DEPTH = (AW+1)'(DEPTH);
  localparam logic [AW:0] LP_BURST = (AW+1)'(BURST);
  localparam logic [AW:0] LP_PRIME = (AW+1)'(PRIME_LEVEL);

  audio_fifo_state_t r_state, w_state_nxt;

  logic [AW-1:0]       r_wptr, r_rptr;
  logic [AW:0]         r_level;
  logic [AW:0]         r_burst_cnt;
  logic                r_req, r_req_out;
  logic                r_ovf, r_udr;
  logic [SAMPLE_W-1:0] w_rdata;

  logic w_active, w_playing, w_empty, w_full;
  logic w_pop, w_push, w_drop, w_udr_evt, w_req_cond;

  assign w_active  = (r_state != ST_IDLE);
  assign w_playing = (r_state == ST_PLAY) || (r_state == ST_DRAIN);
  assign w_empty   = (r_level == '0);
  assign w_full    = (r_level == LP_DEPTH);

  // A flush wins over everything else happening in the same cycle.
  assign w_pop     = out_ready && w_playing && !w_empty && !audio_starts;
  assign w_push    = in_valid && w_active && !audio_starts && (!w_full || w_pop);
  assign w_drop    = in_valid && w_active && !audio_starts && w_full && !w_pop;
  assign w_udr_evt = out_ready && (r_state == ST_PLAY) && w_empty && !audio_starts;

  // Request only while fed and only if a whole burst still fits.
  assign w_req_cond = ((r_state == ST_PRIME) || (r_state == ST_PLAY)) && !r_req_out &&
                      !r_req && !audio_starts && ((LP_DEPTH - r_level) >= LP_BURST);

  sample_ram #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .W     (SAMPLE_W)
  ) u_ram (
    .i_clk   (mon_clk),
    .i_we    (w_push),
    .i_waddr (r_wptr),
    .i_wdata (in_data),
    .i_raddr (r_rptr),
    .o_rdata (w_rdata)
  );

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE:  w_state_nxt = ST_IDLE;
      ST_PRIME: if (r_level >= LP_PRIME) w_state_nxt = ST_PLAY;
      ST_PLAY:  if (w_udr_evt) w_state_nxt = ST_PRIME;
      ST_DRAIN: if (w_empty) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
    if (audio_stop && ((r_state == ST_PRIME) || (r_state == ST_PLAY)))
      w_state_nxt = ST_DRAIN;
    if (audio_starts)
      w_state_nxt = ST_PRIME;
  end

  always_ff @(posedge mon_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_level     <= '0;
      r_burst_cnt <= '0;
      r_req       <= 1'b0;
      r_req_out   <= 1'b0;
      r_ovf       <= 1'b0;
      r_udr       <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (audio_starts) begin
        r_wptr      <= '0;
        r_rptr      <= '0;
        r_level     <= '0;
        r_burst_cnt <= '0;
        r_req       <= 1'b0;
        r_req_out   <= 1'b0;
        r_ovf       <= 1'b0;
        r_udr       <= 1'b0;
      end else begin
        if (w_push) r_wptr <= r_wptr + 1'b1;
        if (w_pop)  r_rptr <= r_rptr + 1'b1;
        if (w_push && !w_pop)      r_level <= r_level + 1'b1;
        else if (w_pop && !w_push) r_level <= r_level - 1'b1;
        if (w_drop)    r_ovf <= 1'b1;
        if (w_udr_evt) r_udr <= 1'b1;

        r_req <= w_req_cond;
        if (w_req_cond) begin
          r_req_out   <= 1'b1;
          r_burst_cnt <= '0;
        end else if (w_push && r_req_out) begin
          // The last word of a burst re-opens the request window.
          if (r_burst_cnt == LP_BURST - 1'b1) begin
            r_req_out   <= 1'b0;
            r_burst_cnt <= '0;
          end else begin
            r_burst_cnt <= r_burst_cnt + 1'b1;
          end
        end
      end
    end
  end

  assign out_valid = w_playing && !w_empty;
  assign out_data  = out_valid ? w_rdata : '0;
  assign audio_req = r_req;
  assign level     = r_level;
  assign overflow  = r_ovf;
  assign underrun  = r_udr;

endmodule

// File: tb/tb_audio_sample_fifo.sv
// Directed bench for audio_sample_fifo: vector table for the prime/play/underrun
// path, hand sequences for overflow, flush, drain and mid-stream reset.
module tb_audio_sample_fifo;
  import nextasic_audio_pkg::*;

  logic                mon_clk = 1'b0;
  logic                reset_n;
  logic                in_valid, audio_starts, audio_stop, out_ready;
  logic [SAMPLE_W-1:0] in_data;
  logic [SAMPLE_W-1:0] out_data;
  logic                out_valid, audio_req, overflow, underrun;
  logic [4:0]          level;

  int total = 0;
  int bad   = 0;

  audio_sample_fifo #(.DEPTH(16), .AW(4), .BURST(4), .PRIME_LEVEL(8)) dut (
    .mon_clk      (mon_clk),
    .reset_n      (reset_n),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .audio_starts (audio_starts),
    .audio_stop   (audio_stop),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .audio_req    (audio_req),
    .level        (level),
    .overflow     (overflow),
    .underrun     (underrun)
  );

  always #5 mon_clk = ~mon_clk;

  typedef struct {
    logic              iv;
    logic [31:0]       d;
    logic              st;
    logic              sp;
    logic              rdy;
    logic [4:0]        lvl;
    logic              ov;
    logic [31:0]       od;
    logic              rq;
    logic              of;
    logic              ur;
    audio_fifo_state_t es;
  } vec_t;

  vec_t vecs[20];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge mon_clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid = 0; in_data = '0; audio_starts = 0; audio_stop = 0; out_ready = 0;
  endtask

  task automatic push(input logic [31:0] d);
    in_valid = 1; in_data = d;
    tick();
    idle_inputs();
  endtask

  function automatic logic [31:0] wa(input int k);
    return {16'(k), 16'(k)};
  endfunction

  function automatic logic [31:0] wb(input int k);
    return 32'hA000_0000 + 32'(k);
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int reqs;
    reset_n = 0;
    idle_inputs();
    #3;
    chk("rst_level", 32'(level), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_req", 32'(audio_req), 0);
    chk("rst_flags", {30'd0, overflow, underrun}, 0);
    tick();
    reset_n = 1;
    tick();
    chk("rst_state", 32'(dut.r_state), 32'(ST_IDLE));

    // ---- table: start, request, prime, play, drain to empty, underrun
    vecs[0] = '{0, 32'h0, 1, 0, 0, 5'd0, 0, 32'h0, 0, 0, 0, ST_PRIME};
    vecs[1] = '{0, 32'h0, 0, 0, 0, 5'd0, 0, 32'h0, 1, 0, 0, ST_PRIME};
    for (int k = 0; k < 8; k++)
      vecs[2+k] = '{1, wa(k+1), 0, 0, 0, 5'(k+1), 0, 32'h0, (k == 4), 0, 0, ST_PRIME};
    vecs[10] = '{0, 32'h0, 0, 0, 0, 5'd8, 1, wa(1), 0, 0, 0, ST_PLAY};
    for (int k = 0; k < 8; k++)
      vecs[11+k] = '{0, 32'h0, 0, 0, 1, 5'(7-k), (k < 7), (k < 7) ? wa(k+2) : 32'h0,
                     0, 0, 0, ST_PLAY};
    vecs[19] = '{0, 32'h0, 0, 0, 1, 5'd0, 0, 32'h0, 0, 0, 1, ST_PRIME};

    for (int i = 0; i < 20; i++) begin
      in_valid = vecs[i].iv; in_data = vecs[i].d; audio_starts = vecs[i].st;
      audio_stop = vecs[i].sp; out_ready = vecs[i].rdy;
      tick();
      idle_inputs();
      chk($sformatf("v%0d_level", i), 32'(level), 32'(vecs[i].lvl));
      chk($sformatf("v%0d_valid", i), 32'(out_valid), 32'(vecs[i].ov));
      chk($sformatf("v%0d_data", i), out_data, vecs[i].od);
      chk($sformatf("v%0d_req", i), 32'(audio_req), 32'(vecs[i].rq));
      chk($sformatf("v%0d_ovf", i), 32'(overflow), 32'(vecs[i].of));
      chk($sformatf("v%0d_udr", i), 32'(underrun), 32'(vecs[i].ur));
      chk($sformatf("v%0d_state", i), 32'(dut.r_state), 32'(vecs[i].es));
    end

    // ---- overflow at full, push+pop at full, pointer wrap
    audio_starts = 1; tick(); idle_inputs();
    chk("flush_udr", 32'(underrun), 0);
    for (int k = 0; k < 16; k++) push(wb(k));
    chk("full_level", 32'(level), 16);
    chk("full_ovf", 32'(overflow), 0);
    chk("full_state", 32'(dut.r_state), 32'(ST_PLAY));
    push(32'hDEAD_0001);
    chk("ovf_level", 32'(level), 16);
    chk("ovf_flag", 32'(overflow), 1);
    chk("pp_head_before", out_data, wb(0));
    in_valid = 1; in_data = 32'hBEEF_0002; out_ready = 1;
    tick(); idle_inputs();
    chk("pp_level", 32'(level), 16);
    chk("pp_head_after", out_data, wb(1));
    for (int k = 0; k < 16; k++) begin
      chk($sformatf("wrap_data%0d", k), out_data, (k < 15) ? wb(k+1) : 32'hBEEF_0002);
      out_ready = 1; tick(); idle_inputs();
    end
    chk("wrap_level", 32'(level), 0);
    chk("wrap_valid", 32'(out_valid), 0);

    // ---- push coinciding with audio_starts at level 6
    for (int k = 0; k < 6; k++) push(wa(k + 32));
    chk("pre_flush_level", 32'(level), 6);
    chk("pre_flush_ovf", 32'(overflow), 1);
    in_valid = 1; in_data = 32'h1234_5678; audio_starts = 1;
    tick(); idle_inputs();
    chk("flush_level", 32'(level), 0);
    chk("flush_ovf", 32'(overflow), 0);
    chk("flush_udr2", 32'(underrun), 0);
    chk("flush_state", 32'(dut.r_state), 32'(ST_PRIME));

    // ---- stop at level 5, drain, then idle ignores pushes
    tick();
    chk("c_req_first", 32'(audio_req), 1);
    for (int k = 0; k < 5; k++) push(wa(k + 64));
    chk("c_level5", 32'(level), 5);
    reqs = 0;
    audio_stop = 1; tick(); idle_inputs();
    chk("c_state_drain", 32'(dut.r_state), 32'(ST_DRAIN));
    if (audio_req) reqs++;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("drain_data%0d", k), out_data, wa(k + 64));
      out_ready = 1; tick(); idle_inputs();
      if (audio_req) reqs++;
    end
    chk("drain_level", 32'(level), 0);
    tick();
    if (audio_req) reqs++;
    chk("drain_no_req", 32'(reqs), 0);
    chk("drain_state_idle", 32'(dut.r_state), 32'(ST_IDLE));
    push(32'h5555_AAAA);
    chk("idle_push_level", 32'(level), 0);
    chk("idle_req", 32'(audio_req), 0);

    // ---- reset mid-play at level 10
    audio_starts = 1; tick(); idle_inputs();
    for (int k = 0; k < 10; k++) push(wa(k + 96));
    chk("e_level", 32'(level), 10);
    chk("e_state", 32'(dut.r_state), 32'(ST_PLAY));
    chk("e_valid", 32'(out_valid), 1);
    reset_n = 0;
    #1;
    chk("mid_rst_level", 32'(level), 0);
    chk("mid_rst_valid", 32'(out_valid), 0);
    chk("mid_rst_data", out_data, 0);
    chk("mid_rst_req", 32'(audio_req), 0);
    tick();
    reset_n = 1;
    tick();
    chk("post_rst_state", 32'(dut.r_state), 32'(ST_IDLE));
    chk("post_rst_level", 32'(level), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
